// File: rtl/result_bcd_emitter_pkg.sv
// Shared types and constants for the result-to-ASCII emitter.
package euler_pkg;

    typedef enum logic [2:0] {IDLE, CONVERT, EMIT_DIG, EMIT_NL, DONE} state_t;

    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [7:0] ASCII_NL   = 8'h0A;

    // Decimal digits needed for a width-bit unsigned value: ceil(width*log10(2)).
    function automatic int digits_for(input int width);
        return (width * 30103 + 99999) / 100000;
    endfunction

endpackage

// File: rtl/result_bcd_emitter_if.sv
// Run trigger, status and ASCII byte stream of the result emitter.
interface result_bcd_emitter_if #(parameter int WIDTH = 32);
    logic             start;
    logic [WIDTH-1:0] value;
    logic             busy;
    logic             done;
    logic             ascii_valid;
    logic [7:0]       ascii_data;
    logic             ascii_ready;

    modport master (
        input  start, value, ascii_ready,
        output busy, done, ascii_valid, ascii_data
    );

    modport slave (
        output start, value, ascii_ready,
        input  busy, done, ascii_valid, ascii_data
    );
endinterface

// File: rtl/result_bcd_emitter_bcd_add3.sv
// Double-dabble correction: every nibble >= 5 gets +3 before the shift.
module bcd_add3 #(
    parameter int DIGITS = 10
) (
    input  logic [DIGITS-1:0][3:0] d,
    output logic [DIGITS-1:0][3:0] q
);
    for (genvar i = 0; i < DIGITS; i++) begin : g_nib
        // Only 5..9 reach here in a valid BCD word, so the sum stays within 4 bits.
        assign q[i] = (d[i] >= 4'd5) ? d[i] + 4'd3 : d[i];
    end
endmodule

// File: rtl/result_bcd_emitter.sv
// Captures a binary result on a start edge, converts it to BCD and streams
// the digits MSD-first as ASCII with leading zeros suppressed, then a newline.
module result_bcd_emitter
    import euler_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int DIGITS = 10
) (
    input logic                  clk,
    input logic                  reset,
    result_bcd_emitter_if.master bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    if (DIGITS < digits_for(WIDTH)) begin : g_bad_digits
        $error("DIGITS too small for WIDTH");
    end

    state_t                  state, state_nxt;
    logic                    start_q;
    logic [WIDTH-1:0]        bin;
    logic [DIGITS-1:0][3:0]  bcd, adj;
    logic [CW-1:0]           cnt;
    logic [IW-1:0]           idx;
    logic                    seen;
    logic [3:0]              nib;
    logic                    edge_det, last_iter, skip, xfer;

    bcd_add3 #(.DIGITS(DIGITS)) u_add3 (.d(bcd), .q(adj));

    assign edge_det  = bus.start & ~start_q;
    assign last_iter = (cnt == CW'(WIDTH - 1));
    assign nib       = bcd[idx];
    // The last digit is never skipped so a zero result still prints "0".
    assign skip      = (nib == 4'd0) && !seen && (idx != '0);
    assign xfer      = bus.ascii_valid && bus.ascii_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (edge_det)                state_nxt = CONVERT;
            CONVERT:  if (last_iter)               state_nxt = EMIT_DIG;
            EMIT_DIG: if (xfer && idx == '0)       state_nxt = EMIT_NL;
            EMIT_NL:  if (xfer)                    state_nxt = DONE;
            DONE:     if (!bus.start)              state_nxt = IDLE;
            default:                               state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.busy        = (state == CONVERT) || (state == EMIT_DIG) || (state == EMIT_NL);
        bus.done        = (state == DONE);
        bus.ascii_valid = 1'b0;
        bus.ascii_data  = 8'h00;
        if (state == EMIT_DIG && !skip) begin
            bus.ascii_valid = 1'b1;
            bus.ascii_data  = ASCII_ZERO + {4'h0, nib};
        end else if (state == EMIT_NL) begin
            bus.ascii_valid = 1'b1;
            bus.ascii_data  = ASCII_NL;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            start_q <= 1'b0;
            bin     <= '0;
            bcd     <= '0;
            cnt     <= '0;
            idx     <= '0;
            seen    <= 1'b0;
        end else begin
            start_q <= bus.start;
            case (state)
                IDLE: if (edge_det) begin
                    bin <= bus.value;
                    bcd <= '0;
                    cnt <= '0;
                end
                CONVERT: begin
                    {bcd, bin} <= {adj, bin} << 1;
                    cnt        <= cnt + 1'b1;
                    if (last_iter) begin
                        idx  <= IW'(DIGITS - 1);
                        seen <= 1'b0;
                    end
                end
                EMIT_DIG: begin
                    if (skip) begin
                        idx <= idx - 1'b1;
                    end else if (bus.ascii_ready) begin
                        seen <= 1'b1;
                        if (idx != '0) idx <= idx - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_result_bcd_emitter.sv
// Directed bench for result_bcd_emitter: byte streams, latency, stalls, reset, retrigger.
module tb_result_bcd_emitter;
    logic clk = 1'b0;
    logic reset;
    int   nvec = 0;
    int   nerr = 0;

    result_bcd_emitter_if #(.WIDTH(32)) bus ();

    result_bcd_emitter #(.WIDTH(32), .DIGITS(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Caller leaves start/reset so the next posedge is the detected edge T.
    task automatic collect(input string exp, input int exp_first, input bit rnd,
                           input int stop_after);
        int nb, firstv;
        bit pv, fin;
        logic [7:0] pd, eb;
        nb = 0; firstv = -1; pv = 0; fin = 0; pd = 8'h00;
        @(posedge clk);
        for (int k = 0; k < 400 && !fin; k++) begin
            @(negedge clk);
            bus.ascii_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (k == 0) begin
                nvec++;
                if (bus.busy !== 1'b1) begin
                    nerr++; $display("FAIL busy_after_start: got %b want 1", bus.busy);
                end
            end
            if (pv) begin
                nvec++;
                if (bus.ascii_valid !== 1'b1 || bus.ascii_data !== pd) begin
                    nerr++;
                    $display("FAIL stall_hold: got v=%b d=%h want v=1 d=%h",
                             bus.ascii_valid, bus.ascii_data, pd);
                end
            end
            if (firstv < 0 && bus.ascii_valid === 1'b1) begin
                firstv = k + 1;
                nvec++;
                if (firstv != exp_first) begin
                    nerr++; $display("FAIL first_valid: got T+%0d want T+%0d", firstv, exp_first);
                end
            end else if (!rnd && firstv >= 0 && bus.ascii_valid !== 1'b1) begin
                nvec++; nerr++;
                $display("FAIL stream_gap: valid low at T+%0d", k + 1);
            end
            if (bus.ascii_valid === 1'b1 && bus.ascii_ready) begin
                nvec++;
                if (nb >= exp.len()) begin
                    nerr++; $display("FAIL extra_byte: got %h want none", bus.ascii_data);
                end else begin
                    eb = exp[nb];
                    if (bus.ascii_data !== eb) begin
                        nerr++; $display("FAIL byte%0d: got %h want %h", nb, bus.ascii_data, eb);
                    end
                end
                nb++;
                if (nb == exp.len() || nb == stop_after) fin = 1;
            end
            pv = (bus.ascii_valid === 1'b1) && !bus.ascii_ready;
            pd = bus.ascii_data;
        end
        if (!fin) begin
            nvec++; nerr++; $display("FAIL timeout: got %0d bytes want %0d", nb, exp.len());
        end else if (stop_after == 0) begin
            @(negedge clk);
            nvec++;
            if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.ascii_valid !== 1'b0) begin
                nerr++;
                $display("FAIL done_state: got done=%b busy=%b v=%b want 1 0 0",
                         bus.done, bus.busy, bus.ascii_valid);
            end
        end
    endtask

    // Drop start for one cycle (DONE -> IDLE), then raise it with a new value.
    task automatic new_run(input logic [31:0] v);
        bus.start = 1'b0;
        @(negedge clk);
        bus.value = v;
        bus.start = 1'b1;
    endtask

    task automatic test_reset;
        reset = 1'b1; bus.start = 1'b0; bus.value = '0; bus.ascii_ready = 1'b1;
        repeat (2) @(negedge clk);
        nvec++;
        if (bus.busy !== 0 || bus.done !== 0 || bus.ascii_valid !== 0 || bus.ascii_data !== 8'h00) begin
            nerr++;
            $display("FAIL reset_values: got busy=%b done=%b v=%b d=%h want 0 0 0 00",
                     bus.busy, bus.done, bus.ascii_valid, bus.ascii_data);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic;
        bus.value = 32'd233168; bus.start = 1'b1;
        collect("233168\n", 37, 1'b0, 0);
    endtask

    task automatic test_zero;
        new_run(32'd0);
        collect("0\n", 42, 1'b0, 0);
    endtask

    task automatic test_max;
        new_run(32'hFFFF_FFFF);
        collect("4294967295\n", 33, 1'b0, 0);
    endtask

    task automatic test_stall;
        new_run(32'd1000000000);
        collect("1000000000\n", 33, 1'b1, 0);
        bus.ascii_ready = 1'b1;
    endtask

    task automatic test_reset_midrun;
        new_run(32'd233168);
        collect("233168\n", 37, 1'b0, 3);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        nvec++;
        if (bus.busy !== 0 || bus.done !== 0 || bus.ascii_valid !== 0 || bus.ascii_data !== 8'h00) begin
            nerr++;
            $display("FAIL midrun_reset: got busy=%b done=%b v=%b d=%h want 0 0 0 00",
                     bus.busy, bus.done, bus.ascii_valid, bus.ascii_data);
        end
        @(negedge clk);
        reset = 1'b0;
        collect("233168\n", 37, 1'b0, 0);
    endtask

    task automatic test_no_retrigger;
        int bad;
        bad = 0;
        bus.value = 32'd7;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.ascii_valid !== 1'b0 || bus.done !== 1'b1) bad++;
        end
        nvec++;
        if (bad != 0) begin
            nerr++; $display("FAIL no_retrigger: got %0d bad cycles want 0", bad);
        end
        new_run(32'd5);
        collect("5\n", 42, 1'b0, 0);
    endtask

    initial begin
        test_reset;
        test_basic;
        test_zero;
        test_max;
        test_stall;
        test_reset_midrun;
        test_no_retrigger;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/result_bcd_emitter.md
# result_bcd_emitter

Downstream consumer of the problem-solver core's `sum`/`isEnd` outputs. On a rising edge of `start` it captures a binary result, converts it to decimal with an iterative shift-add-3 (double-dabble) engine, and streams the digits as ASCII characters over a valid/ready byte interface, most significant digit first. Leading zeros are suppressed and the stream ends with a newline. It feeds the bench's character sink or a later UART stage.

## Interface
- `WIDTH`, 32: binary input width.
- `DIGITS`, 10: BCD digits held. Must satisfy `DIGITS >= ceil(WIDTH*0.30103)`.
- `clk`  in  1  system clock; all state updates on posedge.
- `reset`  in  1  asynchronous, active-high; one clock domain.
- `start`  in  1  level input, connected to `isEnd`; only its 0->1 transition triggers a run.
- `value`  in  WIDTH  binary result; sampled only in the cycle the start edge is detected.
- `busy`  out  1  high in CONVERT and EMIT.
- `ascii_valid`  out  1  character available.
- `ascii_data`  out  8  ASCII byte: '0'..'9' (0x30..0x39) or newline 0x0A.
- `ascii_ready`  in  1  sink accepts when high.
- `done`  out  1  high in DONE.

## Operation
- Edge detect: `start_q` register, reset 0. Edge is `start & ~start_q`.
- IDLE: on edge, load `bin <= value`, clear `bcd` (4*DIGITS bits), `cnt <= 0`, go to CONVERT. Edges outside IDLE are ignored.
- CONVERT, WIDTH cycles: per cycle, add 3 to every nibble >= 5. Then shift `{bcd,bin}` left by 1. After iteration WIDTH-1, go to EMIT. Set `idx <= DIGITS-1` and `seen <= 0`.
- EMIT digit phase, one decision per cycle:
  - If nibble[idx]==0, `seen`==0 and idx>0: skip it. `ascii_valid` stays low and idx decrements.
  - Otherwise present `0x30+nibble[idx]` with valid high. On transfer, set `seen <= 1`. Decrement idx, or after idx==0 move to the newline phase.
- Newline phase: present 0x0A. On transfer, go to DONE.
- The least significant digit is always emitted, so a value of 0 yields "0\n".
- DONE: `done=1`. Return to IDLE when `start==0`. A new run needs a fresh 0->1 edge.
- `ascii_valid` never drops before a transfer. `ascii_data` is stable while valid is high and ready is low.
- Width rule: intermediate nibbles never exceed 4 bits after add-3, since the add applies only to values 5..9.

## Timing
- Reset values: `busy=0`, `done=0`, `ascii_valid=0`, `ascii_data=0x00`. State is IDLE, all registers 0.
- Edge sampled at posedge T. CONVERT occupies T+1..T+WIDTH. The first EMIT decision is at T+WIDTH+1.
- With ready held high, the first character appears at T+WIDTH+1+z, where z is the number of skipped leading zeros. After that, one character transfers per cycle.
- Transfer happens at a posedge where valid and ready are both high. The next character or skip decision follows in the same cycle.
- `reset` mid-run, in any state: immediate return to IDLE and all outputs go to their reset values. A partial stream is abandoned and is not resumed.
- If `start` is still high after reset release, `start_q` resets to 0, so this counts as an edge and a run begins. This is intended: the core re-asserts `isEnd` after its own reset.

## Structure
- Shared package `euler_pkg`:
  - state enum `{IDLE, CONVERT, EMIT_DIG, EMIT_NL, DONE}`
  - constants `ASCII_ZERO=8'h30`, `ASCII_NL=8'h0A`
  - function `digits_for(width)`
- Sub-module `bcd_add3`, combinational: applies the nibble-wise >=5 +3 correction across DIGITS nibbles. It is instantiated once inside the converter.
- Everything else (FSM, counters, output register) lives in `result_bcd_emitter`.

## Test plan
- `value=233168`, ready tied high -> bytes "233168\n" (0x32 0x33 0x33 0x31 0x36 0x38 0x0A). First valid at T+37, then one byte per cycle. `done` follows the newline.
- `value=0` -> exactly "0\n", with 9 skip cycles before the first valid.
- `value=32'hFFFFFFFF` -> "4294967295\n", no zeros skipped, first valid at T+33.
- `value=1000000000`, `ascii_ready` toggled pseudo-randomly -> the same 11-byte stream. Valid and data are held across every stall, with no duplicate or lost bytes.
- Reset asserted after the 3rd transferred byte of 233168 -> all outputs reset within the same cycle. Re-run with `start` held high after release -> a complete fresh "233168\n".
- `start` kept high after DONE, `value` changed -> no second stream. Drop `start` for 1 cycle, raise it with `value=5` -> "5\n".
